gate_vector_checker: RTL and testbench



---
 rtl/gate_chk_pkg.sv | 29 ++
 rtl/gate_chk_settle_timer.sv | 42 ++++
 rtl/gate_vector_checker.sv | 142 ++++++++++++++
 tb/tb_gate_vector_checker.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
//------------------------------------------------------------------------------
// gate_chk_pkg : shared types and truth-table constants for gate_vector_checker
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bit k is the expected output for input vector k.
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gate_chk_settle_timer.sv
//------------------------------------------------------------------------------
// gate_chk_settle_timer : loadable up/down counter with clear and terminal count
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gate_chk_settle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_up,
    input  logic [WIDTH-1:0] i_tc_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // Clear wins over load, load wins over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= i_up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_tc_val);

endmodule

`default_nettype wire

// File: rtl/gate_vector_checker.sv
//------------------------------------------------------------------------------
// gate_vector_checker : drives all input vectors to a gate, samples y after a
// settle time and checks against TRUTH. Option: GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int                          N_IN       = 2,
    parameter logic [tt_width(N_IN)-1:0]   TRUTH      = 4'b1000,
    parameter int                          SETTLE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            y_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            fail_seen
);

    localparam int         c_ERR_W       = N_IN + 1;
    localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_IN-1:0]     r_vec;
    logic [c_ERR_W-1:0]  r_err_count;
    logic [N_IN-1:0]     r_first_fail_vec;
    logic                r_fail_seen;

    logic                w_accept;
    logic                w_mismatch;
    logic                w_last_vec;
    logic                w_tmr_clr;
    logic                w_tmr_en;
    logic                w_tmr_tc;
    logic [3:0]          w_tmr_count;

    assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_mismatch = (r_state == ST_SAMPLE) && (y_in != TRUTH[r_vec]);
    assign w_last_vec = (r_vec == '1);

    gate_chk_settle_timer #(
        .WIDTH (4)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_tmr_clr),
        .i_load     (1'b0),
        .i_load_val (4'd0),
        .i_en       (w_tmr_en),
        .i_up       (1'b1),
        .i_tc_val   (c_SETTLE_LAST),
        .o_count    (w_tmr_count),
        .o_tc       (w_tmr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_clr   = 1'b0;
        w_tmr_en    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_SETTLE;
                    w_tmr_clr   = 1'b1;
                end
            end
            ST_SETTLE: begin
                w_tmr_en = 1'b1;
                if (w_tmr_tc) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_tmr_clr = 1'b1;
`ifdef GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN
                if (w_last_vec || w_mismatch) begin
`else
                if (w_last_vec) begin
`endif
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Vector advances only when the FSM returns to SETTLE, so it holds in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec            <= '0;
            r_err_count      <= '0;
            r_first_fail_vec <= '0;
            r_fail_seen      <= 1'b0;
        end else if (w_accept) begin
            r_vec            <= '0;
            r_err_count      <= '0;
            r_first_fail_vec <= '0;
            r_fail_seen      <= 1'b0;
        end else if (r_state == ST_SAMPLE) begin
            if (w_mismatch) begin
                r_err_count <= r_err_count + c_ERR_W'(1);
                if (!r_fail_seen) begin
                    r_first_fail_vec <= r_vec;
                    r_fail_seen      <= 1'b1;
                end
            end
            if (w_state_nxt == ST_SETTLE) begin
                r_vec <= r_vec + N_IN'(1);
            end
        end
    end

    assign vec_out        = r_vec;
    assign busy           = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign done           = (r_state == ST_DONE);
    assign pass           = done && (r_err_count == '0);
    assign err_count      = r_err_count;
    assign first_fail_vec = r_first_fail_vec;
    assign fail_seen      = r_fail_seen;

endmodule

`default_nettype wire

// File: tb/tb_gate_vector_checker.sv
//------------------------------------------------------------------------------
// tb_gate_vector_checker : directed self-checking bench, two checkers (AND/OR
// truth tables) watching the same modelled gate.
//------------------------------------------------------------------------------
`default_nettype none

module tb_gate_vector_checker;
    import gate_chk_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    int         gate_mode = 0;   // 0 = AND, 1 = OR, 2 = stuck at 0

    logic [1:0] vec_a, vec_b;
    logic       y_a, y_b;
    logic       busy_a, done_a, pass_a, fs_a;
    logic       busy_b, done_b, pass_b, fs_b;
    logic [2:0] err_a, err_b;
    logic [1:0] ffv_a, ffv_b;

    int n_err = 0;
    int n_checks = 0;
    int edges_a, edges_b;
    int vlog [0:15];

    always #5 clk = ~clk;

    function automatic logic gate(input int mode, input logic [1:0] v);
        case (mode)
            0:       return v[0] & v[1];
            1:       return v[0] | v[1];
            default: return 1'b0;
        endcase
    endfunction

    assign y_a = gate(gate_mode, vec_a);
    assign y_b = gate(gate_mode, vec_b);

    gate_vector_checker #(.N_IN(2), .TRUTH(TT_AND2), .SETTLE_CYC(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .vec_out(vec_a), .y_in(y_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail_vec(ffv_a), .fail_seen(fs_a)
    );

    gate_vector_checker #(.N_IN(2), .TRUTH(TT_OR2), .SETTLE_CYC(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .vec_out(vec_b), .y_in(y_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail_vec(ffv_b), .fail_seen(fs_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start (accepted on next edge), then count edges until both finish.
    // inj > 0 re-asserts start so that it is sampled on that edge.
    task automatic run(input int inj);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        vlog[0] = int'(vec_a);
        edges_a = -1;
        edges_b = -1;
        for (int e = 1; e <= 200; e++) begin
            if (e == inj) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (e < 16) vlog[e] = int'(vec_a);
            if (done_a && edges_a < 0) edges_a = e;
            if (done_b && edges_b < 0) edges_b = e;
            if (edges_a >= 0 && edges_b >= 0) break;
        end
        check("run_timeout", 32'(edges_a >= 0 && edges_b >= 0), 32'd1);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_vec", 32'(vec_a), 0);
        check("rst_busy_done_pass", {busy_a, done_a, pass_a, fs_a}, 0);
        check("rst_err_ffv", {err_a, ffv_a}, 0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        // 1: ideal AND gate, vector sequence and latency
        gate_mode = 0;
        run(0);
        check("t1_done_edges", 32'(edges_a), 12);
        for (int k = 0; k < 12; k++) check($sformatf("t1_vec_e%0d", k), 32'(vlog[k]), 32'(k / 3));
        check("t1_pass", {pass_a, err_a, fs_a}, {1'b1, 3'd0, 1'b0});
        check("t1_busy_in_done", 32'(busy_a), 0);
        check("t1_vec_hold", 32'(vec_a), 3);
        check("t1_b_err", 32'(err_b), 2);
        check("t1_b_ffv", 32'(ffv_b), 1);

        // 2: output stuck at 0
        gate_mode = 2;
        run(0);
        check("t2_a_err", 32'(err_a), 1);
        check("t2_a_ffv_fs_pass", {ffv_a, fs_a, pass_a}, {2'd3, 1'b1, 1'b0});
        check("t2_a_edges", 32'(edges_a), 12);
`ifdef GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN
        check("t2_b_err", 32'(err_b), 1);
`else
        check("t2_b_err", 32'(err_b), 3);
`endif
        check("t2_b_ffv", 32'(ffv_b), 1);

        // 5b (restart from DONE with results held): accepting edge clears results
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t5_restart_done", {done_a, busy_a}, {1'b0, 1'b1});
        check("t5_restart_clr", {err_a, fs_a, ffv_a, vec_a}, 0);
        for (int i = 0; i < 30 && !done_a; i++) @(posedge clk);
        #1;

        // 3 / 6: OR gate, AND table and OR table
        gate_mode = 1;
        run(0);
        check("t3_b_pass", {pass_b, err_b}, {1'b1, 3'd0});
        check("t3_b_edges", 32'(edges_b), 12);
        check("t3_a_ffv", {ffv_a, fs_a, pass_a}, {2'd1, 1'b1, 1'b0});
`ifdef GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN
        check("t6_a_edges", 32'(edges_a), 6);
        check("t6_a_err", 32'(err_a), 1);
        check("t6_a_vec", 32'(vec_a), 1);
`else
        check("t3_a_edges", 32'(edges_a), 12);
        check("t3_a_err", 32'(err_a), 2);
        check("t3_a_vec", 32'(vec_a), 3);
`endif

        // 4: asynchronous reset at vector 2
        gate_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 30 && vec_a != 2'd2; i++) @(posedge clk);
        #2;
        check("t4_reached_vec2", 32'(vec_a), 2);
        rst = 1'b1;
        #1;
        check("t4_async_clear", {vec_a, busy_a, done_a, pass_a, err_a, ffv_a, fs_a}, 0);
        @(negedge clk);
        rst = 1'b0;
        run(0);
        check("t4_rerun_edges", 32'(edges_a), 12);
        check("t4_rerun_pass", {pass_a, err_a, fs_a}, {1'b1, 3'd0, 1'b0});

        // 5a: start while busy (vec_out=1) is ignored
        run(4);
        check("t5_inj_vec", 32'(vlog[4]), 1);
        check("t5_busy_ignore_edges", 32'(edges_a), 12);
        check("t5_seq_e7", 32'(vlog[7]), 2);
        check("t5_pass", 32'(pass_a), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
